// File: rtl/cave_ddr_pkg.sv
// Shared DDR initiator-port widths, responder state encoding and the stall LFSR helper.
package cave_ddr_pkg;

    localparam int DDR_DATA_WIDTH  = 64;
    localparam int DDR_MASK_WIDTH  = 8;
    localparam int DDR_BURST_WIDTH = 8;
    localparam int DDR_ADDR_WIDTH  = 32;

    // Feedback bits of the right-shifting 16-bit Fibonacci LFSR (taps 16,14,13,11).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } ddr_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    // A zero burst length means a single beat.
    function automatic logic [DDR_BURST_WIDTH-1:0] burst_beats(input logic [DDR_BURST_WIDTH-1:0] len);
        return (len == '0) ? DDR_BURST_WIDTH'(1) : len;
    endfunction

endpackage

// File: rtl/ddr_resp_ram.sv
// Simple dual-port 64-bit RAM with per-byte write enables and a registered, write-first read port.
module ddr_resp_ram
    import cave_ddr_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-1:0]     waddr_i,
    input  logic [DDR_MASK_WIDTH-1:0] wmask_i,
    input  logic [DDR_DATA_WIDTH-1:0] wdata_i,
    input  logic                      re_i,
    input  logic [ADDR_WIDTH-1:0]     raddr_i,
    output logic [DDR_DATA_WIDTH-1:0] rdata_o
);

    logic [DDR_DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DDR_DATA_WIDTH-1:0] rdata_q;
    logic [DDR_DATA_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DDR_MASK_WIDTH; b++) begin
                if (wmask_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Same-cycle write to the read address is forwarded byte by byte.
    always_comb begin
        rdata_d = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            for (int b = 0; b < DDR_MASK_WIDTH; b++) begin
                if (wmask_i[b]) begin
                    rdata_d[8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ddr_burst_responder.sv
// Avalon-MM burst slave serving the DDR initiator port from on-chip RAM, with optional
// LFSR-driven waitReq stalls and a fixed-latency read return pipeline.
module ddr_burst_responder
    import cave_ddr_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 12,
    parameter int          READ_LATENCY = 2,
    parameter int          STALL_EN     = 0,
    parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ddr_rd,
    input  logic                       ddr_wr,
    input  logic [DDR_ADDR_WIDTH-1:0]  ddr_addr,
    input  logic [DDR_BURST_WIDTH-1:0] ddr_burstLength,
    input  logic [DDR_MASK_WIDTH-1:0]  ddr_mask,
    input  logic [DDR_DATA_WIDTH-1:0]  ddr_din,
    output logic [DDR_DATA_WIDTH-1:0]  ddr_dout,
    output logic                       ddr_valid,
    output logic                       ddr_waitReq,
    output logic                       protocolError
);

    localparam logic [ADDR_WIDTH-1:0] ONE_W = ADDR_WIDTH'(1);

    ddr_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]      ptr_q, ptr_d;
    logic [DDR_BURST_WIDTH-1:0] left_q, left_d;
    logic                       perr_q, perr_d;
    logic                       hold_q;
    logic [15:0]                lfsr_q;
    logic [READ_LATENCY-1:0]    vpipe_q;

    logic [ADDR_WIDTH-1:0]      word;
    logic [DDR_BURST_WIDTH-1:0] beats;
    logic                       stall;
    logic                       wr_acc;
    logic                       rd_acc;
    logic                       ram_we;
    logic                       ram_re;
    logic [ADDR_WIDTH-1:0]      ram_waddr;
    logic [DDR_DATA_WIDTH-1:0]  ram_rdata;
    logic                       unused_addr_bits;

    assign word             = ddr_addr[ADDR_WIDTH+2:3];
    assign unused_addr_bits = ^{ddr_addr[DDR_ADDR_WIDTH-1:ADDR_WIDTH+3], ddr_addr[2:0]};
    assign beats            = burst_beats(ddr_burstLength);
    assign stall            = (STALL_EN != 0) && (lfsr_q[1:0] == 2'b00);

    // hold_q keeps the port closed for one cycle after reset is released.
    assign ddr_waitReq   = reset | hold_q | (state_q == READ) | stall;
    assign wr_acc        = ddr_wr & ~ddr_waitReq;
    assign rd_acc        = ddr_rd & ~ddr_waitReq;
    assign protocolError = perr_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        left_d    = left_q;
        perr_d    = perr_q;
        ram_we    = 1'b0;
        ram_waddr = ptr_q;
        ram_re    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    ram_we    = 1'b1;
                    ram_waddr = word;
                    ptr_d     = word + ONE_W;
                    left_d    = beats - 8'd1;
                    if (beats != 8'd1) state_d = WRITE;
                    if (rd_acc) perr_d = 1'b1;
                end else if (rd_acc) begin
                    state_d = READ;
                    ptr_d   = word;
                    left_d  = beats;
                end
            end
            WRITE: begin
                if (wr_acc) begin
                    ram_we    = 1'b1;
                    ram_waddr = ptr_q;
                    ptr_d     = ptr_q + ONE_W;
                    left_d    = left_q - 8'd1;
                    if (left_q == 8'd1) state_d = IDLE;
                end
                if (rd_acc) perr_d = 1'b1;
            end
            READ: begin
                ram_re = 1'b1;
                ptr_d  = ptr_q + ONE_W;
                left_d = left_q - 8'd1;
                if (left_q == 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            left_q  <= '0;
            perr_q  <= 1'b0;
            hold_q  <= 1'b1;
            lfsr_q  <= STALL_SEED;
            vpipe_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            left_q  <= left_d;
            perr_q  <= perr_d;
            hold_q  <= 1'b0;
            lfsr_q  <= lfsr_next(lfsr_q);
            vpipe_q <= READ_LATENCY'({vpipe_q, ram_re});
        end
    end

    ddr_resp_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i  (clock),
        .rst_i  (reset),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wmask_i(ddr_mask),
        .wdata_i(ddr_din),
        .re_i   (ram_re),
        .raddr_i(ptr_q),
        .rdata_o(ram_rdata)
    );

    assign ddr_valid = vpipe_q[READ_LATENCY-1];

    // The RAM output register is the first latency stage; the rest follow it here.
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign ddr_dout = ram_rdata;
        end else begin : g_pipe
            logic [DDR_DATA_WIDTH-1:0] dpipe_q [READ_LATENCY-1];
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int k = 0; k < READ_LATENCY-1; k++) dpipe_q[k] <= '0;
                end else begin
                    dpipe_q[0] <= ram_rdata;
                    for (int k = 1; k < READ_LATENCY-1; k++) dpipe_q[k] <= dpipe_q[k-1];
                end
            end
            assign ddr_dout = dpipe_q[READ_LATENCY-2];
        end
    endgenerate

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Randomized scoreboard bench for ddr_burst_responder: word-array memory model, expected
// read beats tagged with their return cycle, and a per-cycle waitReq prediction.
module tb_ddr_burst_responder;
  localparam int          AW       = 12;
  localparam int          RL       = 3;
  localparam int          STALL_EN = 1;
  localparam int          DEPTH    = 1 << AW;
  localparam logic [15:0] SEED     = 16'hACE1;

  // Valid/ready: a command or write beat transfers on a rising edge where the bench holds
  // ddr_rd/ddr_wr high and ddr_waitReq is low for that cycle.

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ddr_rd = 1'b0;
  logic        ddr_wr = 1'b0;
  logic [31:0] ddr_addr = '0;
  logic [7:0]  ddr_burstLength = '0;
  logic [7:0]  ddr_mask = '0;
  logic [63:0] ddr_din = '0;
  logic [63:0] ddr_dout;
  logic        ddr_valid;
  logic        ddr_waitReq;
  logic        protocolError;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] mem_m [DEPTH];
  logic [63:0] exp_q [$];
  int          exp_cyc_q [$];
  int          busy_lo = -1;
  int          busy_hi = -2;
  logic        perr_m = 1'b0;
  logic [15:0] lfsr_m;
  logic        hold_m;
  logic        mon_en = 1'b0;
  logic        exp_wait;

  ddr_burst_responder #(
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(RL),
    .STALL_EN    (STALL_EN),
    .STALL_SEED  (SEED)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .ddr_rd         (ddr_rd),
    .ddr_wr         (ddr_wr),
    .ddr_addr       (ddr_addr),
    .ddr_burstLength(ddr_burstLength),
    .ddr_mask       (ddr_mask),
    .ddr_din        (ddr_din),
    .ddr_dout       (ddr_dout),
    .ddr_valid      (ddr_valid),
    .ddr_waitReq    (ddr_waitReq),
    .protocolError  (protocolError)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference stall source: classic right-shift Fibonacci LFSR, feedback of bits 0,2,3,5.
  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      lfsr_m <= SEED;
      hold_m <= 1'b1;
    end else begin
      lfsr_m <= lfsr_ref(lfsr_m);
      hold_m <= 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mk_addr(input int word);
    logic [31:0] a;
    a = $urandom;
    a[AW+2:3] = AW'(word);
    return a;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      exp_wait = hold_m | ((cyc >= busy_lo) && (cyc <= busy_hi)) |
                 ((STALL_EN != 0) && (lfsr_m[1:0] == 2'b00));
      check("waitreq", 64'(ddr_waitReq), 64'(exp_wait));
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL read_beat_missing: no valid seen, required valid at cycle %0d with data %h",
                 exp_cyc_q[0], exp_q[0]);
        void'(exp_cyc_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (ddr_valid !== 1'b0) begin
        if (exp_cyc_q.size() == 0 || exp_cyc_q[0] != cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: valid=%b data %h at cycle %0d, required no valid",
                   ddr_valid, ddr_dout, cyc);
        end else begin
          void'(exp_cyc_q.pop_front());
          check("read_data", ddr_dout, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic put_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [7:0] len, input logic [7:0] mask,
                         input logic [63:0] din, output int acc);
    int n;
    ddr_rd = rd;
    ddr_wr = wr;
    ddr_addr = addr;
    ddr_burstLength = len;
    ddr_mask = mask;
    ddr_din = din;
    n = 0;
    while (ddr_waitReq !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    n_tests++;
    if (ddr_waitReq !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_timeout: waitReq=%b after 100 cycles, required 0", ddr_waitReq);
      acc = -1;
    end else begin
      acc = cyc;
    end
  endtask

  task automatic release_bus();
    @(negedge clock);
    ddr_rd = 1'b0;
    ddr_wr = 1'b0;
  endtask

  // mode 0: random data, full mask; 1: data k+1, full mask; 2: random data, random mask
  task automatic wr_burst(input int base, input logic [7:0] len, input int mode, input int max_gap);
    int n, acc, w;
    logic [63:0] d;
    logic [7:0] m;
    n = (len == 8'd0) ? 1 : int'(len);
    for (int k = 0; k < n; k++) begin
      d = (mode == 1) ? 64'(k + 1) : {$urandom, $urandom};
      m = (mode == 2) ? 8'($urandom) : 8'hFF;
      if (k == 0) put_cmd(1'b0, 1'b1, mk_addr(base), len, m, d, acc);
      else        put_cmd(1'b0, 1'b1, $urandom, 8'($urandom), m, d, acc);
      if (acc >= 0) begin
        w = (base + k) % DEPTH;
        mem_m[w] = merge(mem_m[w], d, m);
      end
      release_bus();
      repeat ($urandom_range(0, max_gap)) @(negedge clock);
    end
  endtask

  task automatic rd_burst(input int base, input logic [7:0] len);
    int n, acc;
    n = (len == 8'd0) ? 1 : int'(len);
    put_cmd(1'b1, 1'b0, mk_addr(base), len, 8'($urandom), {$urandom, $urandom}, acc);
    if (acc >= 0) begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(mem_m[(base + k) % DEPTH]);
        exp_cyc_q.push_back(acc + 1 + k + RL);
      end
      busy_lo = acc + 1;
      busy_hi = acc + n;
    end
    release_bus();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d read beats outstanding, required 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic reset_dut(input int cycles);
    reset = 1'b1;
    @(negedge clock);
    check("rst_valid", 64'(ddr_valid), 64'd0);
    check("rst_dout", ddr_dout, 64'd0);
    check("rst_perr", 64'(protocolError), 64'd0);
    check("rst_waitreq", 64'(ddr_waitReq), 64'd1);
    exp_q.delete();
    exp_cyc_q.delete();
    busy_lo = -1;
    busy_hi = -2;
    perr_m = 1'b0;
    for (int i = 1; i < cycles; i++) begin
      @(negedge clock);
      check("rst_hold_waitreq", 64'(ddr_waitReq), 64'd1);
      check("rst_hold_valid", 64'(ddr_valid), 64'd0);
    end
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    logic [63:0] d;
    repeat (3) @(negedge clock);
    reset_dut(2);
    mon_en = 1'b1;
    @(negedge clock);
    check("hold_after_reset", 64'(ddr_waitReq), 64'd1);

    // single write then read-after-write at byte 0x40
    put_cmd(1'b0, 1'b1, 32'h40, 8'd1, 8'hFF, 64'h0123456789ABCDEF, acc);
    if (acc >= 0) mem_m[8] = 64'h0123456789ABCDEF;
    release_bus();
    rd_burst(8, 8'd1);
    drain();

    // low-half byte mask
    put_cmd(1'b0, 1'b1, 32'h40, 8'd1, 8'h0F, 64'hFFFFFFFFFFFFFFFF, acc);
    if (acc >= 0) mem_m[8] = merge(mem_m[8], 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    release_bus();
    rd_burst(8, 8'd1);
    drain();

    // burst crossing the top of the array
    wr_burst(4094, 8'd4, 1, 0);
    rd_burst(4094, 8'd4);
    rd_burst(0, 8'd2);
    drain();

    // back-to-back reads
    wr_burst(100, 8'd16, 0, 1);
    rd_burst(100, 8'd8);
    rd_burst(108, 8'd8);
    drain();

    // rd and wr together in IDLE: write wins, read dropped
    d = {$urandom, $urandom};
    put_cmd(1'b1, 1'b1, mk_addr(200), 8'd1, 8'hFF, d, acc);
    if (acc >= 0) begin
      mem_m[200] = d;
      perr_m = 1'b1;
    end
    release_bus();
    check("perr_rd_wr_idle", 64'(protocolError), 64'(perr_m));
    repeat (RL + 3) @(negedge clock);
    rd_burst(200, 8'd1);
    drain();

    // reset in the middle of a 16-beat read
    rd_burst(100, 8'd16);
    repeat (5) @(negedge clock);
    reset_dut(3);
    @(negedge clock);
    check("perr_cleared", 64'(protocolError), 64'd0);
    rd_burst(100, 8'd4);
    drain();

    // rd during a write burst
    wr_burst(300, 8'd1, 0, 0);
    d = {$urandom, $urandom};
    put_cmd(1'b0, 1'b1, mk_addr(301), 8'd2, 8'hFF, d, acc);
    if (acc >= 0) mem_m[301] = d;
    release_bus();
    d = {$urandom, $urandom};
    put_cmd(1'b1, 1'b1, $urandom, 8'($urandom), 8'hFF, d, acc);
    if (acc >= 0) begin
      mem_m[302] = d;
      perr_m = 1'b1;
    end
    release_bus();
    check("perr_rd_in_write", 64'(protocolError), 64'(perr_m));
    rd_burst(300, 8'd3);
    drain();

    // long stalled bursts with random initiator gaps
    wr_burst(1000, 8'd255, 0, 2);
    wr_burst(1255, 8'd64, 0, 2);
    rd_burst(1000, 8'd255);
    drain();

    // zero burst length means one beat
    wr_burst(1400, 8'd0, 0, 0);
    wr_burst(1401, 8'd1, 0, 0);
    rd_burst(1400, 8'd0);
    rd_burst(1400, 8'd2);
    drain();

    // random mixed traffic, reads and masked writes overlapping in flight
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) wr_burst(1000 + $urandom_range(0, 280), 8'($urandom_range(0, 16)), 2, 2);
      else                           rd_burst(1000 + $urandom_range(0, 280), 8'($urandom_range(0, 16)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    drain();
    check("perr_final", 64'(protocolError), 64'(perr_m));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
